// File: rtl/dccm_resp.sv
// Word-addressed DCCM responder: zero-clears its array after reset, then serves
// core reads at a fixed RD_LAT (1 or 2) and flags rejected requests on dccm_err.
module dccm_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dccm_wr_en,
  input  logic [31:0] dccm_wr_addr,
  input  logic [31:0] dccm_wr_data,
  input  logic        dccm_rd_en,
  input  logic [31:0] dccm_rd_addr,
  output logic [31:0] dccm_rd_data,
  output logic        dccm_rd_valid,
  output logic        dccm_init_done,
  output logic        dccm_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_clr_idx;
  logic [AW-1:0] w_clr_idx_nxt;
  logic          r_init_done;
  logic          w_init_done_nxt;
  logic          r_err;
  logic          r_p1_valid;
  logic [31:0]   r_p1_data;
  logic [31:0]   r_mem [DEPTH];

  logic [32:0]   w_wr_off;
  logic [32:0]   w_rd_off;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_run;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_reject;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_mem_wdata;
  logic [31:0]   w_rd_sample;

  // 33-bit offset: a borrow into bit 32 means the address lies below BASE_ADDR
  assign w_wr_off = {1'b0, dccm_wr_addr} - {1'b0, BASE_ADDR};
  assign w_rd_off = {1'b0, dccm_rd_addr} - {1'b0, BASE_ADDR};
  assign w_wr_ok  = ~w_wr_off[32] && (w_wr_off[31:AW+2] == {(30-AW){1'b0}})
                    && (w_wr_off[1:0] == 2'b00);
  assign w_rd_ok  = ~w_rd_off[32] && (w_rd_off[31:AW+2] == {(30-AW){1'b0}})
                    && (w_rd_off[1:0] == 2'b00);
  assign w_wr_idx = w_wr_off[AW+1:2];
  assign w_rd_idx = w_rd_off[AW+1:2];

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_acc = w_run && dccm_wr_en && w_wr_ok;
  assign w_rd_acc = w_run && dccm_rd_en;
  assign w_reject = (dccm_wr_en || dccm_rd_en) &&
                    (!w_run || (dccm_wr_en && !w_wr_ok) || (dccm_rd_en && !w_rd_ok));

  // The clear sequencer owns the single write port until RUN
  assign w_mem_we    = !w_run || w_wr_acc;
  assign w_mem_idx   = w_run ? w_wr_idx : r_clr_idx;
  assign w_mem_wdata = w_run ? dccm_wr_data : 32'h0000_0000;

  // Next-state logic for the clear sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_clr_idx_nxt   = r_clr_idx;
    w_init_done_nxt = r_init_done;
    case (r_state)
      ST_INIT: begin
        w_clr_idx_nxt = r_clr_idx + AW'(1'b1);
        if (r_clr_idx == AW'(DEPTH - 1)) begin
          w_state_nxt     = ST_RUN;
          w_init_done_nxt = 1'b1;
        end else begin
          w_state_nxt     = ST_INIT;
          w_init_done_nxt = 1'b0;
        end
      end
      ST_RUN:  w_init_done_nxt = 1'b1;
      default: w_state_nxt     = ST_INIT;
    endcase
  end

  // Read sample is write-first against a same-cycle write to the same word
  always_comb begin
    w_rd_sample = 32'h0000_0000;
    if (!w_rd_ok) begin
      w_rd_sample = 32'h0000_0000;
    end else if (w_wr_acc && (w_wr_idx == w_rd_idx)) begin
      w_rd_sample = dccm_wr_data;
    end else begin
      w_rd_sample = r_mem[w_rd_idx];
    end
  end

  // State, error flag and first read stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_clr_idx   <= {AW{1'b0}};
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_p1_valid  <= 1'b0;
      r_p1_data   <= 32'h0000_0000;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_idx   <= w_clr_idx_nxt;
      r_init_done <= w_init_done_nxt;
      r_err       <= w_reject;
      r_p1_valid  <= w_rd_acc;
      if (w_rd_acc) begin
        r_p1_data <= w_rd_sample;
      end
    end
  end

  // Storage array; contents are defined by the clear sequence, not by reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic        r_p2_valid;
      logic [31:0] r_p2_data;
      // Extra output stage; data holds when nothing completes
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_p2_valid <= 1'b0;
          r_p2_data  <= 32'h0000_0000;
        end else begin
          r_p2_valid <= r_p1_valid;
          if (r_p1_valid) begin
            r_p2_data <= r_p1_data;
          end
        end
      end
      assign dccm_rd_valid = r_p2_valid;
      assign dccm_rd_data  = r_p2_data;
    end else begin : g_lat1
      assign dccm_rd_valid = r_p1_valid;
      assign dccm_rd_data  = r_p1_data;
    end
  endgenerate

  assign dccm_init_done = r_init_done;
  assign dccm_err       = r_err;

endmodule

// File: tb/tb_dccm_resp.sv
// Drives one stimulus stream into an RD_LAT=1 and an RD_LAT=2 responder and
// scoreboards both against an array-based reference model.
module tb_dccm_resp;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] wr_addr = 32'h0, wr_data = 32'h0, rd_addr = 32'h0;
  logic [31:0] d1, d2;
  logic        v1, v2, e1, e2, i1, i2;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {int due; logic [31:0] data;} rd_exp_t;
  rd_exp_t q1[$];
  rd_exp_t q2[$];
  int      errq[$];
  logic [31:0] m_mem [DEPTH];
  bit      m_run = 1'b0;
  int      m_init_cnt = 0;
  logic    exp_init = 1'b0;
  logic [31:0] last1 = 32'h0, last2 = 32'h0;

  dccm_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .dccm_wr_en(wr_en), .dccm_wr_addr(wr_addr), .dccm_wr_data(wr_data),
    .dccm_rd_en(rd_en), .dccm_rd_addr(rd_addr),
    .dccm_rd_data(d1), .dccm_rd_valid(v1), .dccm_init_done(i1), .dccm_err(e1));

  dccm_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .dccm_wr_en(wr_en), .dccm_wr_addr(wr_addr), .dccm_wr_data(wr_data),
    .dccm_rd_en(rd_en), .dccm_rd_addr(rd_addr),
    .dccm_rd_data(d2), .dccm_rd_valid(v2), .dccm_init_done(i2), .dccm_err(e2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit addr_ok(logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    return (la % 4 == 0) && (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  // One clock of stimulus; the model decides the outcome from the request rules
  task automatic step(bit we, logic [31:0] wa, logic [31:0] wd, bit re, logic [31:0] ra);
    logic [31:0] data;
    bit wv, rv;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    wv = addr_ok(wa);
    rv = addr_ok(ra);
    if (!m_run) begin
      if (we || re) errq.push_back(cyc + 1);
    end else begin
      if ((we && !wv) || (re && !rv)) errq.push_back(cyc + 1);
      if (re) begin
        if (!rv) data = 32'h0;
        else if (we && wv && wa == ra) data = wd;
        else data = m_mem[widx(ra)];
        q1.push_back('{cyc + 1, data});
        q2.push_back('{cyc + 2, data});
      end
      if (we && wv) m_mem[widx(wa)] = wd;
    end
    @(posedge clk);
    #1;
    if (!m_run) begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        m_run = 1'b1;
        exp_init = 1'b1;
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    q1.delete(); q2.delete(); errq.delete();
    m_run = 1'b0; m_init_cnt = 0; exp_init = 1'b0;
    last1 = 32'h0; last2 = 32'h0;
    #1;
    chk("rst_rd_data1", d1, 32'h0);
    chk("rst_rd_data2", d2, 32'h0);
    chk("rst_valid", {30'h0, v1, v2}, 32'h0);
    chk("rst_err", {30'h0, e1, e2}, 32'h0);
    chk("rst_init_done", {30'h0, i1, i2}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 32'h0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'b00};
      6:       return {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      7:       return 32'h0000_0040 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      8:       return 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  // Read monitor, RD_LAT=1 instance
  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) begin
        chk("rd1_unexpected_valid", 32'h1, 32'h0);
      end else begin
        chk("rd1_latency", q1[0].due, cyc);
        chk("rd1_data", d1, q1[0].data);
        void'(q1.pop_front());
      end
      last1 = d1;
    end else begin
      chk("rd1_hold", d1, last1);
      if (q1.size() != 0 && q1[0].due <= cyc) begin
        chk("rd1_missing_valid", 32'h0, 32'h1);
        void'(q1.pop_front());
      end
    end
  end

  // Read monitor, RD_LAT=2 instance
  always @(negedge clk) begin
    if (v2) begin
      if (q2.size() == 0) begin
        chk("rd2_unexpected_valid", 32'h1, 32'h0);
      end else begin
        chk("rd2_latency", q2[0].due, cyc);
        chk("rd2_data", d2, q2[0].data);
        void'(q2.pop_front());
      end
      last2 = d2;
    end else begin
      chk("rd2_hold", d2, last2);
      if (q2.size() != 0 && q2[0].due <= cyc) begin
        chk("rd2_missing_valid", 32'h0, 32'h1);
        void'(q2.pop_front());
      end
    end
  end

  // Error pulse and init_done monitor, shared by both instances
  always @(negedge clk) begin
    logic exp_e;
    exp_e = (errq.size() != 0) && (errq[0] == cyc);
    if (exp_e) void'(errq.pop_front());
    chk("err1", {31'h0, e1}, {31'h0, exp_e});
    chk("err2", {31'h0, e2}, {31'h0, exp_e});
    chk("init_done1", {31'h0, i1}, {31'h0, exp_init});
    chk("init_done2", {31'h0, i2}, {31'h0, exp_init});
  end

  initial begin
    logic [31:0] a, b;
    do_reset();
    // Requests during INIT are rejected
    step(1'b1, 32'h0000_0008, 32'h1111_1111, 1'b1, 32'h0000_0008);
    idle(DEPTH + 2);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'(k * 4));
    step(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0008);
    step(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'h0000_0010);
    step(1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0004);
    step(1'b1, 32'h0000_0004, 32'h5A5A_5A5A, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0004);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0040);
    step(1'b1, 32'h0000_0006, 32'hBAD0_BAD0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0004);
    step(1'b1, 32'h0000_0041, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 32'h0000_003C, 32'hCAFE_F00D, 1'b1, 32'h0000_003C);
    idle(3);
    for (int k = 0; k < 400; k++) begin
      a = rand_addr();
      b = ($urandom_range(0, 3) == 0) ? a : rand_addr();
      step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), b);
    end
    idle(3);
    // Reset with a read in flight, then confirm the array is re-cleared
    step(1'b1, 32'h0000_0020, 32'h7777_7777, 1'b0, 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0020);
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'($urandom_range(0, 1)), rand_addr());
    end
    for (int k = 0; k < DEPTH; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'(k * 4));
    idle(4);
    chk("queues_drained", q1.size() + q2.size() + errq.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
